// File: rtl/text_buffer_writer.sv
// Character RAM for a 4x16 text display: takes keyboard characters, keeps the cursor,
// handles backspace/enter/wrap/scroll, and serves a registered read port to the LCD driver.
module text_buffer_writer #(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter logic [7:0] BS_CODE   = 8'h08,
    parameter logic [7:0] CR_CODE   = 8'h0D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [5:0] cursor,
    output logic       busy
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SCROLL_COPY,
        SCROLL_FILL
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [5:0] cursor_q, cursor_d;

    logic       we;
    logic [5:0] wa;
    logic [7:0] wd;

    logic [7:0] ram [64];

    logic printable;
    logic accept;

    assign printable  = (char_data >= 8'h20) && (char_data <= 8'h7E);
    assign char_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign accept     = char_valid && char_ready;
    assign cursor     = cursor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            idx_q    <= '0;
            cursor_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cursor_q <= cursor_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cursor_d = cursor_q;
        we       = 1'b0;
        wa       = idx_q;
        wd       = FILL_CHAR;
        case (state_q)
            CLEAR: begin
                we    = 1'b1;
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) state_d = IDLE;
            end
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        we = 1'b1;
                        wa = cursor_q;
                        wd = char_data;
                        if (cursor_q == 6'd63) begin
                            state_d = SCROLL_COPY;
                            idx_d   = '0;
                        end else begin
                            cursor_d = cursor_q + 6'd1;
                        end
                    end else if (char_data == BS_CODE) begin
                        if (cursor_q != 6'd0) begin
                            cursor_d = cursor_q - 6'd1;
                            we       = 1'b1;
                            wa       = cursor_q - 6'd1;
                        end
                    end else if (char_data == CR_CODE) begin
                        if (cursor_q[5:4] != 2'd3) begin
                            cursor_d = {cursor_q[5:4] + 2'd1, 4'h0};
                        end else begin
                            state_d = SCROLL_COPY;
                            idx_d   = '0;
                        end
                    end
                end
            end
            SCROLL_COPY: begin
                // Ascending copy reads idx+16, which this pass has not yet overwritten
                we    = 1'b1;
                wd    = ram[idx_q + 6'd16];
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd47) state_d = SCROLL_FILL;
            end
            SCROLL_FILL: begin
                we    = 1'b1;
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    cursor_d = 6'd48;
                    state_d  = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) ram[wa] <= wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= ram[rd_addr];
    end

endmodule
